pfvf_route_table: RTL and testbench

Programmable PF/VF-to-port routing table with a pipelined lookup. It replaces fixed per-function PF/VF/VA constants with a runtime table of NUM_ENTRIES entries, written over a simple config port. Each incoming (pf, vf, vf_active) request resolves to a destination port index. It sits between the PCIe TLP demux and the AFU port fan-out, and is shared by the sim and synthesis builds.

---
 rtl/pfvf_route_table.sv | 192 +++++++++++++++++++
 tb/tb_pfvf_route_table.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pfvf_route_table.sv
// PF/VF-to-port routing table with a two-stage lookup pipeline (match, then priority encode).
// Optional multi-hit detection is built when PFVF_ROUTE_DUP_CHECK_EN is defined.
module pfvf_route_table #(
  parameter int unsigned           NUM_ENTRIES  = 8,
  parameter int unsigned           PF_WIDTH     = 3,
  parameter int unsigned           VF_WIDTH     = 11,
  parameter int unsigned           PORT_WIDTH   = 4,
  parameter logic [PORT_WIDTH-1:0] DEFAULT_PORT = '0,
  localparam int unsigned          IDX_W        = $clog2(NUM_ENTRIES)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_wr_valid,
  input  logic [IDX_W-1:0]      cfg_wr_idx,
  input  logic                  cfg_wr_en,
  input  logic [PF_WIDTH-1:0]   cfg_wr_pf,
  input  logic [VF_WIDTH-1:0]   cfg_wr_vf,
  input  logic                  cfg_wr_va,
  input  logic [PORT_WIDTH-1:0] cfg_wr_port,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [PF_WIDTH-1:0]   req_pf,
  input  logic [VF_WIDTH-1:0]   req_vf,
  input  logic                  req_va,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_hit,
  output logic [IDX_W-1:0]      rsp_idx,
  output logic [PORT_WIDTH-1:0] rsp_port,
  input  logic                  cnt_clr,
  output logic [15:0]           miss_cnt,
  output logic                  dup_err
);

  logic [NUM_ENTRIES-1:0] en_q;
  logic [NUM_ENTRIES-1:0] va_q;
  logic [PF_WIDTH-1:0]    pf_q   [NUM_ENTRIES];
  logic [VF_WIDTH-1:0]    vf_q   [NUM_ENTRIES];
  logic [PORT_WIDTH-1:0]  port_q [NUM_ENTRIES];

  logic                   s1_valid_q;
  logic [NUM_ENTRIES-1:0] s1_vec_q;
  logic [PORT_WIDTH-1:0]  s1_port_q;
  logic                   rsp_valid_q;
  logic                   rsp_hit_q;
  logic [IDX_W-1:0]       rsp_idx_q;
  logic [PORT_WIDTH-1:0]  rsp_port_q;
  logic [15:0]            miss_cnt_q, miss_cnt_d;

  logic                   s1_advance;
  logic                   accept;
  logic                   miss_evt;
  logic [NUM_ENTRIES-1:0] match_vec;
  logic [PORT_WIDTH-1:0]  match_port;
  logic                   enc_hit;
  logic [IDX_W-1:0]       enc_idx;

  assign s1_advance = s1_valid_q & (~rsp_valid_q | rsp_ready);
  assign req_ready  = ~s1_valid_q | s1_advance;
  assign accept     = req_valid & req_ready;
  assign miss_evt   = rsp_valid_q & rsp_ready & ~rsp_hit_q;

  // Table storage; a same-edge lookup sees the old contents since match_vec reads the _q values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q <= '0;
      va_q <= '0;
      for (int i = 0; i < int'(NUM_ENTRIES); i++) begin
        pf_q[i]   <= '0;
        vf_q[i]   <= '0;
        port_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(NUM_ENTRIES); i++) begin
        if (cfg_wr_valid && (cfg_wr_idx == IDX_W'(i))) begin
          en_q[i]   <= cfg_wr_en;
          va_q[i]   <= cfg_wr_va;
          pf_q[i]   <= cfg_wr_pf;
          vf_q[i]   <= cfg_wr_vf;
          port_q[i] <= cfg_wr_port;
        end
      end
    end
  end

  // The winning port is captured alongside the vector so later writes cannot alter an
  // in-flight result.
  always_comb begin
    match_vec  = '0;
    match_port = DEFAULT_PORT;
    for (int i = int'(NUM_ENTRIES) - 1; i >= 0; i--) begin
      match_vec[i] = en_q[i] && (pf_q[i] == req_pf) && (va_q[i] == req_va) &&
                     (!req_va || (vf_q[i] == req_vf));
      if (match_vec[i]) begin
        match_port = port_q[i];
      end
    end
  end

  always_comb begin
    enc_hit = 1'b0;
    enc_idx = '0;
    for (int i = int'(NUM_ENTRIES) - 1; i >= 0; i--) begin
      if (s1_vec_q[i]) begin
        enc_hit = 1'b1;
        enc_idx = IDX_W'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_vec_q    <= '0;
      s1_port_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_hit_q   <= 1'b0;
      rsp_idx_q   <= '0;
      rsp_port_q  <= '0;
    end else begin
      if (accept) begin
        s1_valid_q <= 1'b1;
        s1_vec_q   <= match_vec;
        s1_port_q  <= match_port;
      end else if (s1_advance) begin
        s1_valid_q <= 1'b0;
      end

      if (s1_advance) begin
        rsp_valid_q <= 1'b1;
        rsp_hit_q   <= enc_hit;
        rsp_idx_q   <= enc_idx;
        rsp_port_q  <= s1_port_q;
      end else if (rsp_ready) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

  always_comb begin
    miss_cnt_d = miss_cnt_q;
    if (cnt_clr) begin
      miss_cnt_d = '0;
    end else if (miss_evt && (miss_cnt_q != 16'hFFFF)) begin
      miss_cnt_d = miss_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miss_cnt_q <= '0;
    end else begin
      miss_cnt_q <= miss_cnt_d;
    end
  end

`ifdef PFVF_ROUTE_DUP_CHECK_EN
  logic dup_q, dup_d;
  logic multi_hit;

  // Clearing the lowest set bit leaves something only when two or more bits were set.
  assign multi_hit = |(s1_vec_q & (s1_vec_q - {{(NUM_ENTRIES-1){1'b0}}, 1'b1}));

  always_comb begin
    dup_d = dup_q;
    if (cnt_clr) begin
      dup_d = 1'b0;
    end else if (s1_advance && multi_hit) begin
      dup_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dup_q <= 1'b0;
    end else begin
      dup_q <= dup_d;
    end
  end

  assign dup_err = dup_q;
`else
  assign dup_err = 1'b0;
`endif

  assign rsp_valid = rsp_valid_q;
  assign rsp_hit   = rsp_hit_q;
  assign rsp_idx   = rsp_idx_q;
  assign rsp_port  = rsp_port_q;
  assign miss_cnt  = miss_cnt_q;

endmodule

// File: tb/tb_pfvf_route_table.sv
// Scoreboard bench for pfvf_route_table: stimulus pushes model results, a monitor pops and compares.
module tb_pfvf_route_table;

  localparam int N  = 8;
  localparam int IW = 3;
  localparam int PW = 4;
  localparam logic [PW-1:0] DEF_PORT = 4'd0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_wr_valid = 1'b0;
  logic [2:0]  cfg_wr_idx = '0;
  logic        cfg_wr_en = 1'b0;
  logic [2:0]  cfg_wr_pf = '0;
  logic [10:0] cfg_wr_vf = '0;
  logic        cfg_wr_va = 1'b0;
  logic [3:0]  cfg_wr_port = '0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_pf = '0;
  logic [10:0] req_vf = '0;
  logic        req_va = 1'b0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic        rsp_hit;
  logic [2:0]  rsp_idx;
  logic [3:0]  rsp_port;
  logic        cnt_clr = 1'b0;
  logic [15:0] miss_cnt;
  logic        dup_err;

  pfvf_route_table dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_wr_valid (cfg_wr_valid),
    .cfg_wr_idx   (cfg_wr_idx),
    .cfg_wr_en    (cfg_wr_en),
    .cfg_wr_pf    (cfg_wr_pf),
    .cfg_wr_vf    (cfg_wr_vf),
    .cfg_wr_va    (cfg_wr_va),
    .cfg_wr_port  (cfg_wr_port),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_pf       (req_pf),
    .req_vf       (req_vf),
    .req_va       (req_va),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_hit      (rsp_hit),
    .rsp_idx      (rsp_idx),
    .rsp_port     (rsp_port),
    .cnt_clr      (cnt_clr),
    .miss_cnt     (miss_cnt),
    .dup_err      (dup_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          hit;
    logic [IW-1:0] idx;
    logic [PW-1:0] port;
    logic          dup;
  } rsp_t;

  rsp_t exp_q[$];

  // Reference table: what software believes it has written.
  logic          m_en   [N];
  logic [2:0]    m_pf   [N];
  logic [10:0]   m_vf   [N];
  logic          m_va   [N];
  logic [PW-1:0] m_port [N];

  int          n_cmp = 0;
  int          n_fail = 0;
  logic [15:0] exp_miss = '0;
  logic        exp_dup = 1'b0;
  logic        last_acc = 1'b0;

  // Staged stimulus applied at the next negedge by step().
  logic        s_rv = 0, s_va = 0, s_rr = 0, s_wv = 0, s_wen = 0, s_wva = 0, s_clr = 0;
  logic [2:0]  s_pf = 0, s_widx = 0, s_wpf = 0;
  logic [10:0] s_vf = 0, s_wvf = 0;
  logic [3:0]  s_wport = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp_v, $time);
    end
  endtask

  function automatic rsp_t model_lookup(input logic [2:0] pf, input logic [10:0] vf,
                                        input logic va);
    rsp_t r;
    int   nmatch;
    r.hit  = 1'b0;
    r.idx  = '0;
    r.port = DEF_PORT;
    nmatch = 0;
    for (int i = 0; i < N; i++) begin
      if (m_en[i] && m_pf[i] == pf && m_va[i] == va && (!va || m_vf[i] == vf)) begin
        if (nmatch == 0) begin
          r.hit  = 1'b1;
          r.idx  = IW'(i);
          r.port = m_port[i];
        end
        nmatch++;
      end
    end
    r.dup = (nmatch >= 2);
    return r;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      m_en[i] = 0; m_pf[i] = 0; m_vf[i] = 0; m_va[i] = 0; m_port[i] = 0;
    end
  endtask

  task automatic step();
    @(negedge clk);
    req_valid    = s_rv;  req_pf = s_pf;  req_vf = s_vf;  req_va = s_va;
    rsp_ready    = s_rr;
    cfg_wr_valid = s_wv;  cfg_wr_idx = s_widx;  cfg_wr_en = s_wen;  cfg_wr_pf = s_wpf;
    cfg_wr_vf    = s_wvf; cfg_wr_va = s_wva;    cfg_wr_port = s_wport;
    cnt_clr      = s_clr;
    #1;
    last_acc = req_valid && req_ready;
    // Lookup is evaluated against the table before this edge's write.
    if (last_acc) exp_q.push_back(model_lookup(req_pf, req_vf, req_va));
    if (cfg_wr_valid) begin
      m_en[cfg_wr_idx] = cfg_wr_en;   m_pf[cfg_wr_idx] = cfg_wr_pf;
      m_vf[cfg_wr_idx] = cfg_wr_vf;   m_va[cfg_wr_idx] = cfg_wr_va;
      m_port[cfg_wr_idx] = cfg_wr_port;
    end
    s_wv  = 0;
    s_clr = 0;
  endtask

  task automatic wr(input logic [2:0] idx, input logic en, input logic [2:0] pf,
                    input logic va, input logic [10:0] vf, input logic [3:0] port);
    s_wv = 1; s_widx = idx; s_wen = en; s_wpf = pf; s_wva = va; s_wvf = vf; s_wport = port;
  endtask

  task automatic req(input logic [2:0] pf, input logic va, input logic [10:0] vf);
    s_rv = 1; s_pf = pf; s_va = va; s_vf = vf;
  endtask

  task automatic drain();
    int budget;
    s_rv = 0;
    s_rr = 1;
    budget = 0;
    while ((exp_q.size() != 0 || rsp_valid) && budget < 40) begin
      step();
      budget++;
    end
    check("drain_done", 32'(exp_q.size()), 32'd0);
    step();
  endtask

  // Monitor: pops on each handshake and tracks miss_cnt, held outputs and dup_err.
  logic          held = 0;
  logic          h_hit;
  logic [IW-1:0] h_idx;
  logic [PW-1:0] h_port;

  always begin
    logic got_miss;
    rsp_t e;
    @(negedge clk);
    #2;
    if (!rst_n) begin
      exp_miss = '0;
      held     = 0;
    end else begin
      got_miss = 0;
      check("miss_cnt", 32'(miss_cnt), 32'(exp_miss));
      if (held) begin
        check("held_valid", 32'(rsp_valid), 32'd1);
        check("held_rsp", {rsp_hit, rsp_idx, rsp_port}, {h_hit, h_idx, h_port});
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_rsp", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("rsp_hit_idx_port", {rsp_hit, rsp_idx, rsp_port}, {e.hit, e.idx, e.port});
          got_miss = !e.hit;
`ifdef PFVF_ROUTE_DUP_CHECK_EN
          if (e.dup) exp_dup = 1'b1;
`endif
        end
      end
      held   = rsp_valid && !rsp_ready;
      h_hit  = rsp_hit;
      h_idx  = rsp_idx;
      h_port = rsp_port;
      if (cnt_clr) exp_miss = '0;
      else if (got_miss && exp_miss != 16'hFFFF) exp_miss = exp_miss + 16'd1;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int issued;
    int acc;
    model_clear();
    repeat (3) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_rsp", {rsp_valid, rsp_hit, rsp_idx, rsp_port}, 32'd0);
    check("rst_cnt", {dup_err, miss_cnt}, 32'd0);
    rst_n = 1'b1;

    // First lookup on an empty table misses; two register stages to the result.
    s_rr = 1;
    req(0, 0, 0);
    step();
    check("lat_accept", 32'(last_acc), 32'd1);
    s_rv = 0;
    step();
    check("lat_s1_only", 32'(rsp_valid), 32'd0);
    step();
    check("lat_rsp_valid", 32'(rsp_valid), 32'd1);
    drain();
    check("first_miss_cnt", 32'(miss_cnt), 32'd1);

    wr(2, 1, 0, 1, 2, 5);  step();
    req(0, 1, 2);          step();
    req(0, 1, 3);          step();
    drain();

    wr(1, 1, 3, 0, 7, 3);  step();
    req(3, 0, 99);         step();
    drain();

    // Back-to-back with the response side stalled for three cycles.
    issued = 0;
    acc = 0;
    s_rr = 0;
    for (int c = 0; c < 3; c++) begin
      case (issued)
        0: req(0, 1, 2);
        1: req(3, 0, 5);
        2: req(2, 0, 0);
        default: req(0, 1, 2);
      endcase
      step();
      if (last_acc) begin issued++; acc++; end
    end
    check("full_accepts", 32'(acc), 32'd2);
    check("full_req_ready", 32'(req_ready), 32'd0);
    s_rr = 1;
    for (int c = 0; c < 20 && issued < 4; c++) begin
      case (issued)
        0: req(0, 1, 2);
        1: req(3, 0, 5);
        2: req(2, 0, 0);
        default: req(0, 1, 2);
      endcase
      step();
      if (last_acc) issued++;
    end
    check("b2b_issued", 32'(issued), 32'd4);
    drain();

    // Same-edge write is invisible to the lookup it races with, visible to the next.
    wr(0, 1, 5, 0, 0, 7);
    req(5, 0, 0);  step();
    req(5, 0, 0);  step();
    drain();

    wr(0, 1, 6, 0, 0, 9);   step();
    wr(4, 1, 6, 0, 0, 10);  step();
    req(6, 0, 0);           step();
    drain();
    check("dup_err_set", 32'(dup_err), 32'(exp_dup));
    s_clr = 1;
    step();
    exp_dup = 0;
    step();
    check("clr_dup", 32'(dup_err), 32'd0);
    check("clr_miss", 32'(miss_cnt), 32'd0);

    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 4) == 0) begin
        wr(3'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0), 3'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 11'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
      end
      if ($urandom_range(0, 9) < 7) begin
        req(3'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 11'($urandom_range(0, 3)));
      end else begin
        s_rv = 0;
      end
      s_rr = ($urandom_range(0, 9) < 7);
      step();
    end
    drain();
    check("dup_err_rand", 32'(dup_err), 32'(exp_dup));

    // Asynchronous reset with the pipeline full drops results and clears the table.
    s_rr = 0;
    repeat (3) begin req(0, 1, 2); step(); end
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("arst_req_ready", 32'(req_ready), 32'd1);
    check("arst_cnt", {dup_err, miss_cnt}, 32'd0);
    exp_q.delete();
    model_clear();
    exp_dup = 0;
    s_rv = 0;
    req_valid = 0;
    @(negedge clk);
    #3;
    rst_n = 1'b1;
    s_rr = 1;
    req(0, 1, 2);  step();
    drain();

    // Saturating miss counter.
    req(7, 1, 11'h7FF);
    repeat (65540) step();
    drain();
    check("miss_sat", 32'(miss_cnt), 32'hFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
